// File: rtl/video_pkg.sv
// Shared constants and types for the video write buffer: RAM geometry,
// the queued write entry and the arbiter state set.
package video_pkg;

  localparam int unsigned VIDEO_BASE = 64;
  localparam int unsigned VRAM_SIZE  = 254000;
  localparam int unsigned ADDR_W     = 18;
  localparam int unsigned DATA_W     = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } vwb_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } vwb_state_t;

endpackage

// File: rtl/vwb_fifo.sv
// Synchronous write-queue FIFO with head/tail views and an in-place tail
// overwrite port used for write coalescing.
module vwb_fifo
  import video_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       overwrite,
  input  vwb_entry_t                 din,
  output vwb_entry_t                 head,
  output vwb_entry_t                 tail,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  vwb_entry_t         mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_nxt;
  logic               do_push;
  logic               do_pop;

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head = mem[rd_ptr];
  assign tail = mem[wr_ptr - PTR_W'(1)];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) count_nxt = count + CNT_W'(1);
    else if (!do_push && do_pop) count_nxt = count - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == CNT_W'(0));
    end
  end

  // Storage carries no reset; only pointer-covered entries are ever read.
  always_ff @(posedge clk) begin
    if (!clr) begin
      if (do_push) mem[wr_ptr] <= din;
      else if (overwrite) mem[wr_ptr - PTR_W'(1)] <= din;
    end
  end

endmodule

// File: rtl/video_write_buffer.sv
// Queues CPU video writes and arbitrates the single-port video RAM between
// display scan-out reads (always first) and queued writes. Optional write
// coalescing onto the newest queued entry is enabled by VWB_COALESCE_EN.
module video_write_buffer
  import video_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               soft_clr,
  input  logic               wr_en,
  input  logic [31:0]        wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               full,
  output logic               empty,
  input  logic               scan_req,
  input  logic [ADDR_W-1:0]  scan_addr,
  output logic               scan_valid,
  output logic [DATA_W-1:0]  scan_data,
  output logic               vram_we,
  output logic [ADDR_W-1:0]  vram_addr,
  output logic [DATA_W-1:0]  vram_wdata,
  input  logic [DATA_W-1:0]  vram_rdata,
  output logic               range_err,
  output logic [7:0]         drop_cnt
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_READ  = 2'(READ);
  localparam logic [1:0] S_WRITE = 2'(WRITE);
`ifdef VWB_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             in_range;
  logic             accept;
  logic             coalesce;
  logic             push;
  logic             pop;
  logic             drop;
  vwb_entry_t       din;
  vwb_entry_t       head;
  vwb_entry_t       tail;
  logic [CNT_W-1:0] count;

  assign in_range = (wr_addr < 32'(VRAM_SIZE));
  assign din      = '{addr: wr_addr[ADDR_W-1:0], data: wr_data};
  assign pop      = (state_nxt == S_WRITE);

  // Read data arrives straight from the RAM one cycle after the read command.
  assign scan_data = scan_valid ? vram_rdata : '0;

  always_comb begin
    state_nxt = S_IDLE;
    if (soft_clr)    state_nxt = S_IDLE;
    else if (scan_req) state_nxt = S_READ;
    else if (!empty) state_nxt = S_WRITE;
  end

  // Coalescing must not target the entry that is leaving this cycle.
  always_comb begin
    accept   = wr_en && in_range && !soft_clr;
    coalesce = COALESCE && accept && !empty && (tail.addr == din.addr) &&
               !(pop && count == CNT_W'(1));
    push     = accept && !coalesce;
    drop     = push && full && !pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= '0;
      scan_valid <= 1'b0;
      range_err  <= 1'b0;
      drop_cnt   <= '0;
    end else if (soft_clr) begin
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= '0;
      scan_valid <= 1'b0;
      range_err  <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      vram_we <= (state_nxt == S_WRITE);
      if (state_nxt == S_READ) begin
        vram_addr <= scan_addr;
      end else if (state_nxt == S_WRITE) begin
        vram_addr  <= head.addr;
        vram_wdata <= head.data;
      end
      scan_valid <= (state == S_READ);
      if (wr_en && !in_range) range_err <= 1'b1;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  vwb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (soft_clr),
    .push      (push),
    .pop       (pop),
    .overwrite (coalesce),
    .din       (din),
    .head      (head),
    .tail      (tail),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_video_write_buffer.sv
// Self-checking bench for video_write_buffer: queue-based reference model,
// bench-side video RAM, directed scenarios and a randomized soak.
module tb_video_write_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int          VSIZE = 254000;
`ifdef VWB_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        soft_clr;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;
  logic        full;
  logic        empty;
  logic        scan_req;
  logic [17:0] scan_addr;
  logic        scan_valid;
  logic [7:0]  scan_data;
  logic        vram_we;
  logic [17:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
  logic        range_err;
  logic [7:0]  drop_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  video_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .soft_clr   (soft_clr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .scan_req   (scan_req),
    .scan_addr  (scan_addr),
    .scan_valid (scan_valid),
    .scan_data  (scan_data),
    .vram_we    (vram_we),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .vram_rdata (vram_rdata),
    .range_err  (range_err),
    .drop_cnt   (drop_cnt)
  );

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d at t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int init_v(int a);
    return (a * 37 + 11) & 255;
  endfunction

  // Bench-side synchronous single-port RAM.
  int ram [int];
  always @(posedge clk) begin
    if (vram_we === 1'b1) ram[int'(vram_addr)] = int'(vram_wdata);
    vram_rdata <= 8'(ram.exists(int'(vram_addr)) ? ram[int'(vram_addr)] : init_v(int'(vram_addr)));
  end

  // Reference model: a queue of pending writes plus the command on the bus.
  typedef struct { int addr; int data; } ent_t;
  ent_t mq [$];
  int   gold [int];
  int   m_cmd = 0;  // 0 none, 1 read, 2 write
  int   m_addr = 0;
  int   m_data = 0;
  bit   m_valid = 0;
  int   m_sdata = 0;
  bit   m_rerr = 0;
  int   m_drop = 0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_cmd = 0; m_addr = 0; m_data = 0;
      m_valid = 0; m_sdata = 0; m_rerr = 0; m_drop = 0;
    end else begin
      bit   nv;
      int   nd;
      int   pre;
      bit   popped;
      ent_t e;
      if (m_cmd == 2) gold[m_addr] = m_data;
      nv = (m_cmd == 1);
      nd = nv ? (gold.exists(m_addr) ? gold[m_addr] : init_v(m_addr)) : 0;
      if (soft_clr) begin
        mq.delete();
        m_cmd = 0; m_addr = 0; m_data = 0;
        m_valid = 0; m_sdata = 0; m_rerr = 0; m_drop = 0;
      end else begin
        m_valid = nv;
        m_sdata = nd;
        pre = mq.size();
        popped = 0;
        if (scan_req) begin
          m_cmd = 1; m_addr = int'(scan_addr);
        end else if (pre > 0) begin
          e = mq.pop_front();
          m_cmd = 2; m_addr = e.addr; m_data = e.data; popped = 1;
        end else begin
          m_cmd = 0;
        end
        if (wr_en) begin
          if (wr_addr >= 32'(VSIZE)) m_rerr = 1;
          else if (COAL && mq.size() > 0 && mq[$].addr == int'(wr_addr))
            mq[$].data = int'(wr_data);
          else if (pre < DEPTH || popped) begin
            e.addr = int'(wr_addr); e.data = int'(wr_data);
            mq.push_back(e);
          end else if (m_drop < 255) m_drop++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == DEPTH);
      chk("vram_we", vram_we, m_cmd == 2);
      if (m_cmd != 0) chk("vram_addr", vram_addr, m_addr);
      if (m_cmd == 2) chk("vram_wdata", vram_wdata, m_data);
      chk("scan_valid", scan_valid, m_valid);
      chk("scan_data", scan_data, m_sdata);
      chk("range_err", range_err, m_rerr);
      chk("drop_cnt", drop_cnt, m_drop);
    end
  end

  task automatic drive(bit sr, int sa, bit we, int wa, int wd, bit sc);
    scan_req  = sr;
    scan_addr = 18'(sa);
    wr_en     = we;
    wr_addr   = 32'(wa);
    wr_data   = 8'(wd);
    soft_clr  = sc;
  endtask

  initial begin
    int n_we;
    int last_d;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_we", vram_we, 0);
    chk("rst_valid", scan_valid, 0);
    chk("rst_drop", drop_cnt, 0);

    // Write drain
    drive(0, 0, 1, 0, 8'hAA, 0);
    @(negedge clk);
    drive(0, 0, 1, 253999, 8'h55, 0);
    @(negedge clk);
    chk("drain1_we", vram_we, 1);
    chk("drain1_addr", vram_addr, 0);
    chk("drain1_data", vram_wdata, 8'hAA);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("drain2_we", vram_we, 1);
    chk("drain2_addr", vram_addr, 253999);
    chk("drain2_data", vram_wdata, 8'h55);
    chk("drain_empty", empty, 1);
    @(negedge clk);
    chk("drain_idle_we", vram_we, 0);

    // Read priority and latency
    for (int i = 0; i < 4; i++) begin
      drive(1, 10 + i, i < 3, 200 + i, i + 1, 0);
      @(negedge clk);
      chk("rp_we_burst", vram_we, 0);
      chk("rp_valid_burst", scan_valid, i > 0);
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rp_valid_tail", scan_valid, i == 0);
      chk("rp_we_tail", vram_we, i < 3);
      if (i < 3) chk("rp_addr_tail", vram_addr, 200 + i);
    end

    // Full and drop
    drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      drive(1, i, 1, 100 + i, 8'h30 + i, 0);
      @(negedge clk);
      if (i == 6) chk("fd_not_full", full, 0);
      if (i == 7) chk("fd_full", full, 1);
    end
    chk("fd_drop", drop_cnt, 2);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("fd_we", vram_we, 1);
      chk("fd_addr", vram_addr, 100 + i);
      chk("fd_data", vram_wdata, 8'h30 + i);
    end
    @(negedge clk);
    chk("fd_empty", empty, 1);
    chk("fd_we_done", vram_we, 0);

    // Range error and soft clear
    drive(0, 0, 1, 254000, 1, 0);
    @(negedge clk);
    chk("re_flag", range_err, 1);
    chk("re_empty", empty, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 300 + i, i, 0);
      @(negedge clk);
    end
    chk("sc_pre_empty", empty, 0);
    drive(0, 0, 0, 0, 0, 1);
    @(negedge clk);
    chk("sc_empty", empty, 1);
    chk("sc_range_err", range_err, 0);
    chk("sc_drop", drop_cnt, 0);
    chk("sc_we", vram_we, 0);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sc_no_we", vram_we, 0);
    end

    // Coalescing onto the newest entry
    drive(1, 0, 1, 5, 8'h11, 0);
    @(negedge clk);
    drive(1, 0, 1, 5, 8'h22, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    n_we = 0;
    last_d = -1;
    repeat (4) begin
      @(negedge clk);
      if (vram_we === 1'b1) begin
        n_we++;
        last_d = int'(vram_wdata);
      end
    end
    chk("coal_writes", n_we, COAL ? 1 : 2);
    chk("coal_last_data", last_d, 8'h22);

    // Randomized soak
    for (int c = 0; c < 4000; c++) begin
      int r;
      int wa;
      int sa;
      r = $urandom_range(0, 9);
      if (r < 7) wa = $urandom_range(0, 15);
      else if (r < 9) wa = $urandom_range(253990, 254010);
      else wa = int'($urandom);
      sa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 253999) : $urandom_range(0, 15);
      drive(($urandom_range(0, 9) < 4), sa, ($urandom_range(0, 9) < 6), wa,
            $urandom_range(0, 255), ($urandom_range(0, 199) == 0));
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (DEPTH + 4) @(negedge clk);
    chk("final_empty", empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
